pcie_ingress_mc: RTL and testbench

// - Parametrised ingress TLP parser between the PCIe core RX AXI-stream and the Nysa control/buffer logic.
// - Decodes MWr TLPs into control-register writes and command strobes.
// - Routes CplD payloads by tag into one of NUM_BUFS read buffers, honouring valid/ready on every beat.
// - Flags malformed packets; silently drops unsupported TLP types.

---
 rtl/pcie_ingress_mc_pkg.sv | 29 ++
 rtl/pcie_ingress_mc_hdr_decode.sv | 39 +++
 rtl/pcie_ingress_mc.sv | 263 ++++++++++++++++++++++++++
 tb/tb_pcie_ingress_mc.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ingress_mc_pkg.sv
// Shared types, TLP field positions and helpers for the ingress TLP parser.
package pcie_ingress_mc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRegData,
        StCmdCnt,
        StCmdAddr,
        StCplData,
        StDrop
    } state_e;

    localparam logic [31:0] CMD_OFFSET_DEFAULT = 32'h20;

    localparam logic [4:0] TLP_TYPE_MEM = 5'b00000;
    localparam logic [4:0] TLP_TYPE_CPL = 5'b01010;
    localparam logic [2:0] TLP_FMT_CPLD = 3'b010;

    localparam int unsigned HDR_TAG_LSB        = 8;
    localparam int unsigned CPL_BYTE_CNT_LSB   = 0;
    localparam int unsigned CPL_BYTE_CNT_WIDTH = 12;

    // A zero length field encodes the maximum of 1024 dwords.
    function automatic logic [10:0] tlp_len_dw(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/pcie_ingress_mc_hdr_decode.sv
// Combinational TLP header decode: type class, size, length, address and completion fields.
module pcie_ingress_mc_hdr_decode
    import pcie_ingress_mc_pkg::*;
(
    input  logic [31:0] hdr0_i,
    input  logic [31:0] hdr1_i,
    input  logic [31:0] hdr2_i,
    input  logic [31:0] hdr3_i,
    output logic        hdr_4dw_o,
    output logic        is_mwr_o,
    output logic        is_cpld_o,
    output logic [10:0] len_o,
    output logic [29:0] addr_o,
    output logic [7:0]  tag_o,
    output logic [6:0]  lower_addr_o,
    output logic [11:0] byte_count_o
);

    logic [2:0] fmt;
    logic [4:0] tlp_type;
    logic       unused_bits;

    always_comb begin
        fmt          = hdr0_i[31:29];
        tlp_type     = hdr0_i[28:24];
        hdr_4dw_o    = fmt[0];
        is_mwr_o     = !fmt[2] && fmt[1] && (tlp_type == TLP_TYPE_MEM);
        is_cpld_o    = (fmt == TLP_FMT_CPLD) && (tlp_type == TLP_TYPE_CPL);
        len_o        = tlp_len_dw(hdr0_i[9:0]);
        // 64-bit addressing carries the low address word in the fourth dword.
        addr_o       = fmt[0] ? hdr3_i[31:2] : hdr2_i[31:2];
        tag_o        = hdr2_i[HDR_TAG_LSB +: 8];
        lower_addr_o = hdr2_i[6:0];
        byte_count_o = hdr1_i[CPL_BYTE_CNT_LSB +: CPL_BYTE_CNT_WIDTH];
    end

    assign unused_bits = ^{hdr0_i[23:10], hdr1_i[31:12], hdr2_i[1:0], hdr3_i[1:0]};

endmodule

// File: rtl/pcie_ingress_mc.sv
// Ingress TLP parser: MWr to control registers / command strobes, CplD payload into tag buffers.
module pcie_ingress_mc
    import pcie_ingress_mc_pkg::*;
#(
    parameter int unsigned  NUM_BUFS   = 4,
    parameter int unsigned  BUF_AW     = 10,
    parameter int unsigned  MAX_RD_DW  = 128,
    parameter int unsigned  REG_AW     = 8,
    parameter logic [31:0]  CMD_OFFSET = CMD_OFFSET_DEFAULT,
    localparam int unsigned SEL_W      = $clog2(NUM_BUFS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_axis_data,
    input  logic              i_axis_valid,
    input  logic              i_axis_last,
    output logic              o_axis_ready,
    input  logic [31:0]       i_control_addr_base,
    output logic              o_reg_wr_stb,
    output logic [REG_AW-1:0] o_reg_addr,
    output logic [31:0]       o_reg_data,
    output logic              o_cmd_stb,
    output logic [REG_AW-1:0] o_cmd_code,
    output logic [31:0]       o_cmd_count,
    output logic [31:0]       o_cmd_addr,
    input  logic              i_buf_ready,
    output logic              o_buf_we,
    output logic [SEL_W-1:0]  o_buf_sel,
    output logic [BUF_AW-1:0] o_buf_addr,
    output logic [31:0]       o_buf_data,
    output logic              o_cpl_done_stb,
    output logic [SEL_W-1:0]  o_cpl_done_sel,
    output logic              o_err_malformed_stb,
    output logic              o_drop_stb
);

    state_e              state_q, state_d;
    logic [31:0]         hdr0_q, hdr0_d, hdr1_q, hdr1_d, hdr2_q, hdr2_d;
    logic [1:0]          hdr_cnt_q, hdr_cnt_d;
    logic [10:0]         left_q, left_d;
    logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                final_q, final_d;
    logic                reg_wr_stb_q, reg_wr_stb_d;
    logic [REG_AW-1:0]   reg_addr_q, reg_addr_d, cmd_code_q, cmd_code_d;
    logic [31:0]         reg_data_q, reg_data_d, cmd_count_q, cmd_count_d, cmd_addr_q, cmd_addr_d;
    logic                cmd_stb_q, cmd_stb_d, err_q, err_d, drop_q, drop_d;

    logic                axis_ready, accept, buf_we, cpl_done;
    logic [31:0]         hdr2_w;
    logic                dec_4dw, dec_mwr, dec_cpld;
    logic [10:0]         dec_len;
    logic [29:0]         dec_addr;
    logic [7:0]          dec_tag;
    logic [6:0]          dec_lower;
    logic [11:0]         dec_bc;
    logic                last_hdr, is_cmd;
    logic [31:0]         offset, cmd_off, cpl_base;
    logic                unused_bits;

    // The final header dword is decoded straight off the bus in the cycle it is accepted.
    assign hdr2_w = (hdr_cnt_q == 2'd2) ? i_axis_data : hdr2_q;

    pcie_ingress_mc_hdr_decode u_hdr_decode (
        .hdr0_i       (hdr0_q),
        .hdr1_i       (hdr1_q),
        .hdr2_i       (hdr2_w),
        .hdr3_i       (i_axis_data),
        .hdr_4dw_o    (dec_4dw),
        .is_mwr_o     (dec_mwr),
        .is_cpld_o    (dec_cpld),
        .len_o        (dec_len),
        .addr_o       (dec_addr),
        .tag_o        (dec_tag),
        .lower_addr_o (dec_lower),
        .byte_count_o (dec_bc)
    );

    assign last_hdr = (hdr_cnt_q == (dec_4dw ? 2'd3 : 2'd2));
    assign offset   = {2'b00, dec_addr} - i_control_addr_base;
    assign is_cmd   = (offset >= CMD_OFFSET);
    assign cmd_off  = offset - CMD_OFFSET;
    assign cpl_base = ((32'(dec_tag) >> SEL_W) * 32'(MAX_RD_DW)) + 32'(dec_lower[6:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            hdr0_q       <= '0;
            hdr1_q       <= '0;
            hdr2_q       <= '0;
            hdr_cnt_q    <= '0;
            left_q       <= '0;
            buf_addr_q   <= '0;
            sel_q        <= '0;
            final_q      <= 1'b0;
            reg_wr_stb_q <= 1'b0;
            reg_addr_q   <= '0;
            reg_data_q   <= '0;
            cmd_stb_q    <= 1'b0;
            cmd_code_q   <= '0;
            cmd_count_q  <= '0;
            cmd_addr_q   <= '0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr0_q       <= hdr0_d;
            hdr1_q       <= hdr1_d;
            hdr2_q       <= hdr2_d;
            hdr_cnt_q    <= hdr_cnt_d;
            left_q       <= left_d;
            buf_addr_q   <= buf_addr_d;
            sel_q        <= sel_d;
            final_q      <= final_d;
            reg_wr_stb_q <= reg_wr_stb_d;
            reg_addr_q   <= reg_addr_d;
            reg_data_q   <= reg_data_d;
            cmd_stb_q    <= cmd_stb_d;
            cmd_code_q   <= cmd_code_d;
            cmd_count_q  <= cmd_count_d;
            cmd_addr_q   <= cmd_addr_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr0_d       = hdr0_q;
        hdr1_d       = hdr1_q;
        hdr2_d       = hdr2_q;
        hdr_cnt_d    = hdr_cnt_q;
        left_d       = left_q;
        buf_addr_d   = buf_addr_q;
        sel_d        = sel_q;
        final_d      = final_q;
        reg_wr_stb_d = 1'b0;
        reg_addr_d   = reg_addr_q;
        reg_data_d   = reg_data_q;
        cmd_stb_d    = 1'b0;
        cmd_code_d   = cmd_code_q;
        cmd_count_d  = cmd_count_q;
        cmd_addr_d   = cmd_addr_q;
        err_d        = 1'b0;
        drop_d       = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    hdr0_d    = i_axis_data;
                    hdr_cnt_d = 2'd1;
                    if (i_axis_last) err_d = 1'b1;
                    else             state_d = StHdr;
                end
                StHdr: begin
                    if (!last_hdr) begin
                        if (hdr_cnt_q == 2'd1) hdr1_d = i_axis_data;
                        else                   hdr2_d = i_axis_data;
                        hdr_cnt_d = hdr_cnt_q + 2'd1;
                        if (i_axis_last) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end else if ((dec_mwr || dec_cpld) && i_axis_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (dec_mwr) begin
                        if (!is_cmd && dec_len == 11'd1) begin
                            state_d    = StRegData;
                            reg_addr_d = offset[REG_AW-1:0];
                        end else if (is_cmd && dec_len == 11'd2) begin
                            state_d    = StCmdCnt;
                            cmd_code_d = cmd_off[REG_AW-1:0];
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end
                    end else if (dec_cpld) begin
                        state_d    = StCplData;
                        sel_d      = dec_tag[SEL_W-1:0];
                        buf_addr_d = cpl_base[BUF_AW-1:0];
                        left_d     = dec_len;
                        final_d    = ({1'b0, dec_bc} <= {dec_len, 2'b00});
                    end else begin
                        drop_d  = 1'b1;
                        state_d = i_axis_last ? StIdle : StDrop;
                    end
                end
                StRegData: begin
                    if (i_axis_last) begin
                        reg_wr_stb_d = 1'b1;
                        reg_data_d   = i_axis_data;
                        state_d      = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
                StCmdCnt: begin
                    cmd_count_d = i_axis_data;
                    if (i_axis_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StCmdAddr;
                    end
                end
                StCmdAddr: begin
                    cmd_addr_d = i_axis_data;
                    if (i_axis_last) begin
                        cmd_stb_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
                StCplData: begin
                    buf_addr_d = buf_addr_q + {{(BUF_AW-1){1'b0}}, 1'b1};
                    left_d     = left_q - 11'd1;
                    if (left_q == 11'd1) begin
                        state_d = i_axis_last ? StIdle : StDrop;
                        err_d   = !i_axis_last;
                    end else if (i_axis_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (i_axis_last) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        axis_ready = !rst && ((state_q != StCplData) || i_buf_ready);
        accept     = i_axis_valid && axis_ready;
        buf_we     = accept && (state_q == StCplData);
        cpl_done   = buf_we && (left_q == 11'd1) && i_axis_last && final_q;
    end

    assign o_axis_ready        = axis_ready;
    assign o_buf_we            = buf_we;
    assign o_buf_sel           = buf_we ? sel_q : '0;
    assign o_buf_addr          = buf_we ? buf_addr_q : '0;
    assign o_buf_data          = buf_we ? i_axis_data : '0;
    assign o_cpl_done_stb      = cpl_done;
    assign o_cpl_done_sel      = cpl_done ? sel_q : '0;
    assign o_reg_wr_stb        = reg_wr_stb_q;
    assign o_reg_addr          = reg_addr_q;
    assign o_reg_data          = reg_data_q;
    assign o_cmd_stb           = cmd_stb_q;
    assign o_cmd_code          = cmd_code_q;
    assign o_cmd_count         = cmd_count_q;
    assign o_cmd_addr          = cmd_addr_q;
    assign o_err_malformed_stb = err_q;
    assign o_drop_stb          = drop_q;

    assign unused_bits = ^{offset[31:REG_AW], cmd_off[31:REG_AW], cpl_base[31:BUF_AW],
                           dec_lower[1:0], dec_tag[7:SEL_W]};

endmodule

// File: tb/tb_pcie_ingress_mc.sv
// Directed self-checking bench for pcie_ingress_mc with default parameters.
module tb_pcie_ingress_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_axis_data;
    logic        i_axis_valid, i_axis_last, o_axis_ready;
    logic [31:0] i_control_addr_base;
    logic        o_reg_wr_stb, o_cmd_stb, o_buf_we, o_cpl_done_stb, o_err_malformed_stb, o_drop_stb;
    logic [7:0]  o_reg_addr, o_cmd_code;
    logic [31:0] o_reg_data, o_cmd_count, o_cmd_addr, o_buf_data;
    logic        i_buf_ready;
    logic [1:0]  o_buf_sel, o_cpl_done_sel;
    logic [9:0]  o_buf_addr;

    int checks = 0;
    int failures = 0;

    int n_reg, n_cmd, n_err, n_drop, n_done, n_multi, done_idx;
    logic [7:0]  m_reg_addr, m_cmd_code;
    logic [31:0] m_reg_data, m_cmd_count, m_cmd_addr;
    logic [1:0]  m_done_sel;
    logic [9:0]  wr_addr[$];
    logic [1:0]  wr_sel[$];
    logic [31:0] wr_data[$];

    pcie_ingress_mc dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_axis_data         (i_axis_data),
        .i_axis_valid        (i_axis_valid),
        .i_axis_last         (i_axis_last),
        .o_axis_ready        (o_axis_ready),
        .i_control_addr_base (i_control_addr_base),
        .o_reg_wr_stb        (o_reg_wr_stb),
        .o_reg_addr          (o_reg_addr),
        .o_reg_data          (o_reg_data),
        .o_cmd_stb           (o_cmd_stb),
        .o_cmd_code          (o_cmd_code),
        .o_cmd_count         (o_cmd_count),
        .o_cmd_addr          (o_cmd_addr),
        .i_buf_ready         (i_buf_ready),
        .o_buf_we            (o_buf_we),
        .o_buf_sel           (o_buf_sel),
        .o_buf_addr          (o_buf_addr),
        .o_buf_data          (o_buf_data),
        .o_cpl_done_stb      (o_cpl_done_stb),
        .o_cpl_done_sel      (o_cpl_done_sel),
        .o_err_malformed_stb (o_err_malformed_stb),
        .o_drop_stb          (o_drop_stb)
    );

    always #5 clk = ~clk;

    // Event recorder; inputs change 1ns after posedge so negedge sees settled values.
    always @(negedge clk) begin
        if (o_reg_wr_stb) begin
            n_reg      <= n_reg + 1;
            m_reg_addr <= o_reg_addr;
            m_reg_data <= o_reg_data;
        end
        if (o_cmd_stb) begin
            n_cmd       <= n_cmd + 1;
            m_cmd_code  <= o_cmd_code;
            m_cmd_count <= o_cmd_count;
            m_cmd_addr  <= o_cmd_addr;
        end
        if (o_cpl_done_stb) begin
            n_done     <= n_done + 1;
            m_done_sel <= o_cpl_done_sel;
            done_idx   <= wr_addr.size();
        end
        if (o_buf_we) begin
            wr_addr.push_back(o_buf_addr);
            wr_sel.push_back(o_buf_sel);
            wr_data.push_back(o_buf_data);
        end
        if (o_err_malformed_stb) n_err <= n_err + 1;
        if (o_drop_stb) n_drop <= n_drop + 1;
        if (int'(o_reg_wr_stb) + int'(o_cmd_stb) + int'(o_cpl_done_stb) > 1) n_multi <= n_multi + 1;
    end

    task automatic clear_mon();
        n_reg = 0; n_cmd = 0; n_err = 0; n_drop = 0; n_done = 0; n_multi = 0; done_idx = -1;
        wr_addr.delete(); wr_sel.delete(); wr_data.delete();
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        int n;
        @(posedge clk); #1;
        i_axis_valid = 1'b1; i_axis_data = d; i_axis_last = l;
        @(negedge clk);
        n = 0;
        while (!o_axis_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL beat_timeout ready=%b required=1", o_axis_ready);
        end
    endtask

    task automatic idle(input int c);
        @(posedge clk); #1;
        i_axis_valid = 1'b0; i_axis_last = 1'b0; i_axis_data = '0;
        repeat (c) @(posedge clk);
    endtask

    task automatic send_reg_3dw(input logic [31:0] byte_addr, input logic [31:0] d);
        beat(32'h4000_0001, 1'b0);
        beat(32'h0000_000F, 1'b0);
        beat(byte_addr, 1'b0);
        beat(d, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_axis_valid = 1'b0; i_axis_last = 1'b0; i_axis_data = '0;
        i_buf_ready = 1'b1; i_control_addr_base = 32'h1000;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (|{o_reg_wr_stb, o_reg_addr, o_reg_data, o_cmd_stb, o_cmd_code, o_cmd_count, o_cmd_addr,
              o_buf_we, o_buf_sel, o_buf_addr, o_buf_data, o_cpl_done_stb, o_cpl_done_sel,
              o_err_malformed_stb, o_drop_stb, o_axis_ready} !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=nonzero required=all zero");
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_axis_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle_ready got=%b required=1", o_axis_ready);
        end
    endtask

    task automatic test_reg_write();
        clear_mon();
        send_reg_3dw(32'h0000_4008, 32'hDEAD_BEEF);
        idle(3);
        checks++;
        if (n_reg !== 1) begin failures++; $display("FAIL reg_count got=%0d required=1", n_reg); end
        checks++;
        if (m_reg_addr !== 8'h02) begin failures++; $display("FAIL reg_addr got=%h required=02", m_reg_addr); end
        checks++;
        if (m_reg_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL reg_data got=%h required=deadbeef", m_reg_data);
        end
        checks++;
        if (n_cmd + n_err + n_drop + wr_addr.size() !== 0) begin
            failures++; $display("FAIL reg_side_effects got=%0d required=0", n_cmd + n_err + n_drop);
        end
    endtask

    task automatic test_cmd();
        clear_mon();
        beat(32'h4000_0002, 1'b0);
        beat(32'h0000_00FF, 1'b0);
        beat(32'h0000_408C, 1'b0);
        beat(32'h0000_0010, 1'b0);
        beat(32'h0000_8000, 1'b1);
        idle(3);
        checks++;
        if (n_cmd !== 1 || n_reg !== 0) begin
            failures++; $display("FAIL cmd_count_stb got=%0d/%0d required=1/0", n_cmd, n_reg);
        end
        checks++;
        if (m_cmd_code !== 8'h03) begin failures++; $display("FAIL cmd_code got=%h required=03", m_cmd_code); end
        checks++;
        if (m_cmd_count !== 32'h10 || m_cmd_addr !== 32'h8000) begin
            failures++;
            $display("FAIL cmd_fields got=%h/%h required=10/8000", m_cmd_count, m_cmd_addr);
        end
    endtask

    task automatic test_cpld();
        clear_mon();
        beat(32'h4A00_0004, 1'b0);
        beat(32'h0000_0010, 1'b0);
        beat(32'h0000_0508, 1'b0);
        for (int k = 0; k < 4; k++) beat(32'hC0DE_0000 + k, k == 3);
        idle(3);
        checks++;
        if (wr_addr.size() !== 4) begin
            failures++; $display("FAIL cpld_writes got=%0d required=4", wr_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wr_addr[k] !== 10'h082 + k || wr_sel[k] !== 2'd1 || wr_data[k] !== 32'hC0DE_0000 + k) begin
                    failures++;
                    $display("FAIL cpld_write%0d got=%h/%h/%h required=%h/1/%h", k, wr_addr[k], wr_sel[k],
                             wr_data[k], 10'h082 + k, 32'hC0DE_0000 + k);
                end
            end
        end
        checks++;
        if (n_done !== 1 || done_idx !== 3 || m_done_sel !== 2'd1) begin
            failures++;
            $display("FAIL cpld_done got=%0d@%0d sel=%0d required=1@3 sel=1", n_done, done_idx, m_done_sel);
        end
        checks++;
        if (n_err !== 0) begin failures++; $display("FAIL cpld_err got=%0d required=0", n_err); end
    endtask

    task automatic test_backpressure();
        int k, cyc;
        logic acc;
        clear_mon();
        beat(32'h4A00_0004, 1'b0);
        beat(32'h0000_0010, 1'b0);
        beat(32'h0000_0508, 1'b0);
        @(posedge clk); #1;
        i_axis_valid = 1'b1; i_axis_data = 32'hB000_0000; i_axis_last = 1'b0; i_buf_ready = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            @(negedge clk);
            checks++;
            if (o_axis_ready !== i_buf_ready) begin
                failures++;
                $display("FAIL bp_ready got=%b required=%b", o_axis_ready, i_buf_ready);
            end
            acc = o_axis_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < 4) begin i_axis_data = 32'hB000_0000 + k; i_axis_last = (k == 3); end
                else begin i_axis_valid = 1'b0; i_axis_last = 1'b0; end
            end
            i_buf_ready = ~i_buf_ready;
            cyc++;
        end
        i_buf_ready = 1'b1;
        idle(3);
        checks++;
        if (wr_addr.size() !== 4) begin
            failures++; $display("FAIL bp_writes got=%0d required=4", wr_addr.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (wr_addr[j] !== 10'h082 + j || wr_data[j] !== 32'hB000_0000 + j) begin
                    failures++;
                    $display("FAIL bp_write%0d got=%h/%h required=%h/%h", j, wr_addr[j], wr_data[j],
                             10'h082 + j, 32'hB000_0000 + j);
                end
            end
        end
        checks++;
        if (n_done !== 1 || done_idx !== 3) begin
            failures++; $display("FAIL bp_done got=%0d@%0d required=1@3", n_done, done_idx);
        end
    endtask

    task automatic test_early_last();
        clear_mon();
        beat(32'h4A00_0004, 1'b0);
        beat(32'h0000_0010, 1'b0);
        beat(32'h0000_0508, 1'b0);
        beat(32'hE000_0000, 1'b0);
        beat(32'hE000_0001, 1'b1);
        beat(32'h0000_0001, 1'b0);
        beat(32'h0000_000F, 1'b0);
        beat(32'h0000_4000, 1'b1);
        idle(3);
        checks++;
        if (wr_addr.size() !== 2) begin
            failures++; $display("FAIL early_writes got=%0d required=2", wr_addr.size());
        end
        checks++;
        if (n_err !== 1 || n_drop !== 1) begin
            failures++; $display("FAIL early_err_drop got=%0d/%0d required=1/1", n_err, n_drop);
        end
        checks++;
        if (n_done + n_reg + n_cmd !== 0) begin
            failures++; $display("FAIL early_other got=%0d required=0", n_done + n_reg + n_cmd);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        // Register-region MWr with length 2 is malformed.
        beat(32'h4000_0002, 1'b0);
        beat(32'h0000_00FF, 1'b0);
        beat(32'h0000_4004, 1'b0);
        beat(32'h1111_1111, 1'b0);
        beat(32'h2222_2222, 1'b1);
        // Non-final CplD: tag 2 -> buffer 2 base 0, byte count exceeds payload.
        beat(32'h4A00_0002, 1'b0);
        beat(32'h0000_0040, 1'b0);
        beat(32'h0000_0200, 1'b0);
        beat(32'h3333_3333, 1'b0);
        beat(32'h4444_4444, 1'b1);
        // 4DW MWr to register offset 4.
        beat(32'h6000_0001, 1'b0);
        beat(32'h0000_000F, 1'b0);
        beat(32'h0000_0000, 1'b0);
        beat(32'h0000_4010, 1'b0);
        beat(32'h0000_A5A5, 1'b1);
        idle(3);
        checks++;
        if (n_err !== 1) begin failures++; $display("FAIL b2b_err got=%0d required=1", n_err); end
        checks++;
        if (wr_addr.size() !== 2) begin
            failures++; $display("FAIL b2b_writes got=%0d required=2", wr_addr.size());
        end else if (wr_addr[0] !== 10'h000 || wr_addr[1] !== 10'h001 || wr_sel[1] !== 2'd2
                     || wr_data[1] !== 32'h4444_4444) begin
            failures++;
            $display("FAIL b2b_write_fields got=%h/%h/%h/%h required=000/001/2/44444444",
                     wr_addr[0], wr_addr[1], wr_sel[1], wr_data[1]);
        end
        checks++;
        if (n_done !== 0) begin failures++; $display("FAIL b2b_no_done got=%0d required=0", n_done); end
        checks++;
        if (n_reg !== 1 || m_reg_addr !== 8'h04 || m_reg_data !== 32'h0000_A5A5) begin
            failures++;
            $display("FAIL b2b_reg4dw got=%0d/%h/%h required=1/04/0000a5a5", n_reg, m_reg_addr, m_reg_data);
        end
        checks++;
        if (n_multi !== 0) begin failures++; $display("FAIL b2b_multi_stb got=%0d required=0", n_multi); end
    endtask

    task automatic test_reset_mid_cpld();
        beat(32'h4A00_0004, 1'b0);
        beat(32'h0000_0010, 1'b0);
        beat(32'h0000_0508, 1'b0);
        beat(32'hF000_0000, 1'b0);
        beat(32'hF000_0001, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; i_axis_data = 32'hF000_0002;
        @(negedge clk);
        checks++;
        if (o_axis_ready !== 1'b0 || o_buf_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b/%b required=0/0", o_axis_ready, o_buf_we);
        end
        @(posedge clk); #1;
        i_axis_valid = 1'b0; i_axis_last = 1'b0;
        @(negedge clk);
        checks++;
        if (|{o_reg_wr_stb, o_reg_addr, o_reg_data, o_cmd_stb, o_cmd_code, o_cmd_count, o_cmd_addr,
              o_buf_we, o_buf_sel, o_buf_addr, o_buf_data, o_cpl_done_stb, o_cpl_done_sel,
              o_err_malformed_stb, o_drop_stb, o_axis_ready} !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=nonzero required=all zero");
        end
        @(posedge clk); #1; rst = 1'b0;
        clear_mon();
        send_reg_3dw(32'h0000_4014, 32'h1234_5678);
        idle(3);
        checks++;
        if (n_reg !== 1 || m_reg_addr !== 8'h05 || m_reg_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rst_mid_next got=%0d/%h/%h required=1/05/12345678", n_reg, m_reg_addr, m_reg_data);
        end
        checks++;
        if (n_err + n_drop + n_done + wr_addr.size() !== 0) begin
            failures++;
            $display("FAIL rst_mid_quiet got=%0d required=0", n_err + n_drop + n_done + wr_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_cmd();
        test_cpld();
        test_backpressure();
        test_early_last();
        test_back_to_back();
        test_reset_mid_cpld();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
